voice_scheduler: RTL and testbench
==================================

# voice_scheduler

Time-multiplexes one shared per-voice sample engine across up to NUM_VOICES active voices once per codec sample period. It sits between the codec conditioner's generate_next_sample strobe and the note-player datapath. On each strobe it requests one sample per active voice, routes each result into left/right mix accumulators according to that voice's stereo side, and presents the finished stereo pair with a one-cycle valid pulse.

## Interface
Parameters:
- NUM_VOICES, 3: number of voice slots, 1..8
- SAMPLE_W, 16: signed sample width, for engine output and mix output
- VOICE_IDX_W, 2: width of eng_voice; must be ≥ max(1, ceil(log2(NUM_VOICES)))

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- generate_next_sample  in  1  one-cycle strobe starting a mix period
- voice_active  in  NUM_VOICES  per-voice enable; snapshot taken at strobe acceptance
- voice_side  in  2*NUM_VOICES  per-voice stereo side: 00 both, 01 left only, 10 right only, 11 muted
- eng_req  out  1  request to the shared sample engine
- eng_voice  out  VOICE_IDX_W  voice index being requested; stable while eng_req=1
- eng_ack  in  1  engine reply; eng_sample is valid in this cycle
- eng_sample  in  SAMPLE_W  signed sample for eng_voice
- mix_left  out  SAMPLE_W  registered left mix
- mix_right  out  SAMPLE_W  registered right mix
- mix_valid  out  1  one-cycle pulse when mix_left/mix_right update
- overrun  out  1  sticky; set when a strobe arrives while busy

## Operation
- States: IDLE, ISSUE, DONE.
- IDLE, strobe high:
  - latch voice_active into mask_q and voice_side into side_q
  - clear accumulators acc_l/acc_r
  - go to ISSUE with idx = lowest set bit of mask_q, or to DONE if mask_q = 0
- ISSUE:
  - eng_req=1 and eng_voice=idx
  - wait indefinitely for eng_ack
  - on ack, add eng_sample into acc_l and/or acc_r per side_q[idx], then clear mask_q[idx]
  - if no mask bits remain, go to DONE; otherwise idx becomes the next lowest set bit and the state stays ISSUE
- DONE: mix_left/mix_right ← acc_l/acc_r; mix_valid=1 for exactly this cycle; then go to IDLE.
- Arithmetic: accumulators are SAMPLE_W+3 bits signed, and sign extension is mandatory. The result is narrowed to SAMPLE_W per Configuration.
- eng_ack outside ISSUE is ignored.
- Strobe in ISSUE or DONE: ignored, and overrun is set. overrun clears only on reset.
- Changes to voice_active or voice_side mid-period have no effect until the next accepted strobe.
- Muted voice (side 11): still requested, so the engine phase advances; its sample is discarded.

## Timing
- Reset values: state IDLE, eng_req 0, eng_voice 0, mix_left 0, mix_right 0, mix_valid 0, overrun 0. Reset takes effect immediately, including mid-ISSUE; eng_req drops asynchronously.
- eng_req is a Moore output of ISSUE. eng_ack may be high in the first ISSUE cycle (zero-wait engine).
- Let the strobe be sampled at edge k and every ack be same-cycle. With N active voices, ISSUE occupies cycles k+1..k+N and mix_valid is high in cycle k+N+1.
- With N=0, mix_valid is high in cycle k+1 with zero outputs.
- Each engine wait cycle adds exactly one cycle of latency.
- Back-to-back: a strobe in the mix_valid cycle is an overrun. A strobe one cycle later is accepted.

## Configuration
- VOICE_SCHED_SAT_EN defined: the final narrowing saturates each channel to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1].
- VOICE_SCHED_SAT_EN undefined: the final value is acc arithmetic-shifted right by 2 and truncated to SAMPLE_W. This gives fixed 1/4 headroom with no clipping logic.

## Structure
- Shared package voice_sched_pkg holds:
  - state encoding constants (IDLE, ISSUE, DONE)
  - side codes (SIDE_BOTH, SIDE_LEFT, SIDE_RIGHT, SIDE_MUTE)
  - the accumulator guard width (3)
- Sub-module voice_scan: combinational lowest-set-bit finder over NUM_VOICES. It returns the index and a none flag, and is used both at strobe acceptance and after each ack.

## Test plan
- Reset mid-ISSUE (voice 1 pending, eng_req=1) → eng_req, mix_valid, overrun, and mix outputs all 0 immediately; the next strobe starts cleanly from voice 0.
- voice_active=3'b101, sides 01/–/10, zero-wait engine returning 1000 then −500; strobe at edge 0 → eng_voice sequence 0, 2 in cycles 1–2; mix_valid in cycle 3 with left=1000, right=−500 (SAT_EN), or left=250, right=−125 (no SAT_EN).
- voice_active=0, strobe → mix_valid in the next cycle, mix_left=mix_right=0, eng_req never asserted.
- All 3 voices side 00, engine returns 0x7FFF each with 2 wait cycles per voice → eng_req held with eng_voice stable through each wait; mix_valid in cycle 10; SAT_EN gives 0x7FFF on both outputs, no SAT_EN gives 0x5FFF on both.
- Second strobe while in ISSUE, plus stray eng_ack in IDLE → overrun=1 and stays 1; the in-flight mix completes unchanged; the stray ack has no effect.
- voice_side changed during ISSUE (voice 0 from 01 to 10) → routing follows the value latched at strobe; the sample appears only on mix_left.

Source files
------------

// File: rtl/voice_sched_pkg.sv
// Shared definitions for the voice scheduler: FSM states, stereo side codes
// and accumulator guard width.
package voice_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] SIDE_BOTH  = 2'b00;
  localparam logic [1:0] SIDE_LEFT  = 2'b01;
  localparam logic [1:0] SIDE_RIGHT = 2'b10;
  localparam logic [1:0] SIDE_MUTE  = 2'b11;

  // Three guard bits hold the sum of up to eight full-scale voices.
  localparam int ACC_GUARD = 3;

endpackage

// File: rtl/voice_scan.sv
// Combinational lowest-set-bit finder over the voice mask; none_o flags an
// empty mask (idx_o is then zero).
module voice_scan
  import voice_sched_pkg::*;
#(
  parameter int NUM_VOICES  = 3,
  parameter int VOICE_IDX_W = 2
) (
  input  logic [NUM_VOICES-1:0]  mask_i,
  output logic [VOICE_IDX_W-1:0] idx_o,
  output logic                   none_o
);

  // Scanning from the top down lets the lowest set bit win.
  always_comb begin
    idx_o = '0;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (mask_i[i]) idx_o = VOICE_IDX_W'(i);
    end
  end

  assign none_o = ~|mask_i;

endmodule

// File: rtl/voice_scheduler.sv
// Time-multiplexes a shared sample engine over the active voices once per
// codec sample period and mixes the results into a stereo pair.
// Optional macro VOICE_SCHED_SAT_EN: saturate instead of shifting right by 2.
module voice_scheduler
  import voice_sched_pkg::*;
#(
  parameter int NUM_VOICES  = 3,
  parameter int SAMPLE_W    = 16,
  parameter int VOICE_IDX_W = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    generate_next_sample,
  input  logic [NUM_VOICES-1:0]   voice_active,
  input  logic [2*NUM_VOICES-1:0] voice_side,
  output logic                    eng_req,
  output logic [VOICE_IDX_W-1:0]  eng_voice,
  input  logic                    eng_ack,
  input  logic [SAMPLE_W-1:0]     eng_sample,
  output logic [SAMPLE_W-1:0]     mix_left,
  output logic [SAMPLE_W-1:0]     mix_right,
  output logic                    mix_valid,
  output logic                    overrun
);

  localparam int ACC_W = SAMPLE_W + ACC_GUARD;

  state_t                  state_q, state_d;
  logic [NUM_VOICES-1:0]   mask_q, mask_d, mask_cleared, scan_in;
  logic [2*NUM_VOICES-1:0] side_q, side_d;
  logic [VOICE_IDX_W-1:0]  idx_q, idx_d, scan_idx;
  logic                    scan_none;
  logic [ACC_W-1:0]        acc_l_q, acc_l_d, acc_r_q, acc_r_d, sample_ext;
  logic [SAMPLE_W-1:0]     mix_l_q, mix_l_d, mix_r_q, mix_r_d;
  logic                    overrun_q, overrun_d;
  logic [1:0]              cur_side;

  function automatic logic [SAMPLE_W-1:0] narrow(input logic [ACC_W-1:0] acc);
`ifdef VOICE_SCHED_SAT_EN
    if (acc[ACC_W-1:SAMPLE_W-1] == {(ACC_GUARD + 1){acc[ACC_W-1]}})
      narrow = acc[SAMPLE_W-1:0];
    else if (acc[ACC_W-1])
      narrow = {1'b1, {(SAMPLE_W - 1){1'b0}}};
    else
      narrow = {1'b0, {(SAMPLE_W - 1){1'b1}}};
`else
    narrow = SAMPLE_W'($signed(acc) >>> 2);
`endif
  endfunction

  // One scanner serves both the fresh snapshot and the post-ack remainder.
  assign scan_in = (state_q == IDLE) ? voice_active : mask_cleared;

  voice_scan #(
    .NUM_VOICES (NUM_VOICES),
    .VOICE_IDX_W(VOICE_IDX_W)
  ) u_scan (
    .mask_i(scan_in),
    .idx_o (scan_idx),
    .none_o(scan_none)
  );

  assign sample_ext = {{ACC_GUARD{eng_sample[SAMPLE_W-1]}}, eng_sample};

  always_comb begin
    cur_side     = SIDE_MUTE;
    mask_cleared = mask_q;
    for (int i = 0; i < NUM_VOICES; i++) begin
      if (VOICE_IDX_W'(i) == idx_q) begin
        cur_side        = side_q[2*i +: 2];
        mask_cleared[i] = 1'b0;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    side_d    = side_q;
    idx_d     = idx_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    mix_l_d   = mix_l_q;
    mix_r_d   = mix_r_q;
    overrun_d = overrun_q | (generate_next_sample && (state_q != IDLE));

    unique case (state_q)
      IDLE: begin
        if (generate_next_sample) begin
          mask_d  = voice_active;
          side_d  = voice_side;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = scan_idx;
          state_d = scan_none ? DONE : ISSUE;
        end
      end
      ISSUE: begin
        if (eng_ack) begin
          if (cur_side == SIDE_BOTH || cur_side == SIDE_LEFT)  acc_l_d = acc_l_q + sample_ext;
          if (cur_side == SIDE_BOTH || cur_side == SIDE_RIGHT) acc_r_d = acc_r_q + sample_ext;
          mask_d  = mask_cleared;
          idx_d   = scan_idx;
          state_d = scan_none ? DONE : ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Mix registers load on entry to DONE so they are valid with mix_valid.
    if (state_d == DONE && state_q != DONE) begin
      mix_l_d = narrow(acc_l_d);
      mix_r_d = narrow(acc_r_d);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mask_q    <= '0;
      side_q    <= '0;
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      mix_l_q   <= '0;
      mix_r_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mask_q    <= mask_d;
      side_q    <= side_d;
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      mix_l_q   <= mix_l_d;
      mix_r_q   <= mix_r_d;
      overrun_q <= overrun_d;
    end
  end

  assign eng_req   = (state_q == ISSUE);
  assign eng_voice = eng_req ? idx_q : '0;
  assign mix_valid = (state_q == DONE);
  assign mix_left  = mix_l_q;
  assign mix_right = mix_r_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Self-checking bench for voice_scheduler: directed scenarios plus random
// periods against a sum-and-narrow reference model with a modelled engine.
module tb_voice_scheduler;

  localparam int NV = 3;
  localparam int SW = 16;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            generate_next_sample;
  logic [NV-1:0]   voice_active;
  logic [2*NV-1:0] voice_side;
  logic            eng_req;
  logic [IW-1:0]   eng_voice;
  logic            eng_ack;
  logic [SW-1:0]   eng_sample;
  logic [SW-1:0]   mix_left;
  logic [SW-1:0]   mix_right;
  logic            mix_valid;
  logic            overrun;

  int vectors = 0;
  int miscompares = 0;

  logic signed [SW-1:0] smp[NV];
  int                   wt[NV];
  int                   midAction;
  logic [2*NV-1:0]      midSide;
  logic                 expOverrun;

  voice_scheduler #(.NUM_VOICES(NV), .SAMPLE_W(SW), .VOICE_IDX_W(IW)) dut (
    .clk                 (clk),
    .reset               (reset),
    .generate_next_sample(generate_next_sample),
    .voice_active        (voice_active),
    .voice_side          (voice_side),
    .eng_req             (eng_req),
    .eng_voice           (eng_voice),
    .eng_ack             (eng_ack),
    .eng_sample          (eng_sample),
    .mix_left            (mix_left),
    .mix_right           (mix_right),
    .mix_valid           (mix_valid),
    .overrun             (overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [SW-1:0] model_narrow(input int sum);
    int r;
`ifdef VOICE_SCHED_SAT_EN
    r = sum;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
`else
    r = (sum >= 0) ? sum / 4 : -((-sum + 3) / 4);
`endif
    return r[SW-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Strobes one period and acts as the engine; returns in the mix_valid cycle.
  task automatic run_period(input logic [NV-1:0] act, input logic [2*NV-1:0] side, input string tag);
    int       q[$];
    int       sumL, sumR, expCyc, cyc, pos, waitCnt;
    bit       done;
    logic [1:0] sd;
    sumL = 0; sumR = 0; expCyc = 1;
    for (int i = 0; i < NV; i++) begin
      if (act[i]) begin
        q.push_back(i);
        sd = side[2*i +: 2];
        if (sd == 2'b00 || sd == 2'b01) sumL += smp[i];
        if (sd == 2'b00 || sd == 2'b10) sumR += smp[i];
        expCyc += wt[i] + 1;
      end
    end
    voice_active = act;
    voice_side   = side;
    generate_next_sample = 1'b1;
    step();
    cyc = 1; pos = 0; waitCnt = 0; done = 0;
    while (!done && cyc < 100) begin
      generate_next_sample = (cyc == 1 && midAction == 1);
      if (cyc == 1 && midAction == 2) voice_side = midSide;
      eng_ack = 1'b0;
      if (mix_valid) begin
        vectors++;
        if (cyc !== expCyc) begin
          miscompares++;
          $display("FAIL latency[%s]: mix_valid at cycle %0d, required %0d", tag, cyc, expCyc);
        end
        vectors++;
        if (pos !== q.size()) begin
          miscompares++;
          $display("FAIL served[%s]: %0d voices acked, required %0d", tag, pos, q.size());
        end
        vectors++;
        if (mix_left !== model_narrow(sumL)) begin
          miscompares++;
          $display("FAIL mix_left[%s]: got %h required %h", tag, mix_left, model_narrow(sumL));
        end
        vectors++;
        if (mix_right !== model_narrow(sumR)) begin
          miscompares++;
          $display("FAIL mix_right[%s]: got %h required %h", tag, mix_right, model_narrow(sumR));
        end
        done = 1;
      end else if (eng_req) begin
        vectors++;
        if (pos >= q.size() || eng_voice !== IW'(q[pos])) begin
          miscompares++;
          $display("FAIL order[%s]: eng_voice=%0d required=%0d", tag, eng_voice,
                   (pos < q.size()) ? q[pos] : -1);
        end else if (waitCnt == wt[q[pos]]) begin
          eng_ack = 1'b1;
          eng_sample = smp[q[pos]];
          pos++;
          waitCnt = 0;
        end else begin
          eng_sample = SW'($urandom);
          waitCnt++;
        end
      end else begin
        vectors++;
        miscompares++;
        $display("FAIL busy[%s]: eng_req=0 and mix_valid=0 in cycle %0d", tag, cyc);
      end
      if (!done) begin
        step();
        cyc++;
      end
    end
    generate_next_sample = 1'b0;
    eng_ack = 1'b0;
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL timeout[%s]: no mix_valid within %0d cycles", tag, cyc);
    end
    vectors++;
    if (overrun !== expOverrun) begin
      miscompares++;
      $display("FAIL overrun[%s]: got %b required %b", tag, overrun, expOverrun);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    generate_next_sample = 1'b0;
    voice_active = '0;
    voice_side = '0;
    eng_ack = 1'b0;
    eng_sample = '0;
    midAction = 0;
    midSide = '0;
    expOverrun = 1'b0;
    step();
    step();
    vectors++;
    if ({eng_req, eng_voice, mix_valid, overrun, mix_left, mix_right} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: req=%b voice=%0d valid=%b ovr=%b l=%h r=%h required all 0",
               eng_req, eng_voice, mix_valid, overrun, mix_left, mix_right);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_basic();
    smp[0] = 16'sd1000; smp[1] = 16'sd1234; smp[2] = -16'sd500;
    wt[0] = 0; wt[1] = 0; wt[2] = 0;
    run_period(3'b101, 6'b10_00_01, "basic");
    vectors++;
`ifdef VOICE_SCHED_SAT_EN
    if (mix_left !== 16'd1000 || mix_right !== 16'hFE0C) begin
`else
    if (mix_left !== 16'd250 || mix_right !== 16'hFF83) begin
`endif
      miscompares++;
      $display("FAIL basic_const: l=%h r=%h", mix_left, mix_right);
    end
    step();
  endtask

  task automatic test_empty();
    run_period(3'b000, 6'b00_00_00, "empty");
    step();
  endtask

  task automatic test_waits();
    for (int i = 0; i < NV; i++) begin
      smp[i] = 16'sh7FFF;
      wt[i] = 2;
    end
    run_period(3'b111, 6'b00_00_00, "waits");
    vectors++;
`ifdef VOICE_SCHED_SAT_EN
    if (mix_left !== 16'h7FFF || mix_right !== 16'h7FFF) begin
`else
    if (mix_left !== 16'h5FFF || mix_right !== 16'h5FFF) begin
`endif
      miscompares++;
      $display("FAIL waits_const: l=%h r=%h", mix_left, mix_right);
    end
    step();
  endtask

  task automatic test_overrun();
    eng_ack = 1'b1;
    eng_sample = 16'h4000;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if (eng_req !== 1'b0 || mix_valid !== 1'b0 || overrun !== 1'b0) begin
        miscompares++;
        $display("FAIL stray_ack: req=%b valid=%b ovr=%b required 0 0 0", eng_req, mix_valid, overrun);
      end
    end
    smp[0] = 16'sd300; smp[1] = -16'sd7000; smp[2] = 16'sd12;
    wt[0] = 1; wt[1] = 1; wt[2] = 1;
    midAction = 1;
    expOverrun = 1'b1;
    run_period(3'b111, 6'b01_10_00, "overrun");
    midAction = 0;
    step();
  endtask

  task automatic test_side_change();
    smp[0] = 16'sd4000; wt[0] = 0;
    midAction = 2;
    midSide = 6'b00_00_10;
    run_period(3'b001, 6'b00_00_01, "side_change");
    midAction = 0;
    vectors++;
    if (mix_right !== 16'd0) begin
      miscompares++;
      $display("FAIL side_latch: mix_right=%h required 0000", mix_right);
    end
    step();
  endtask

  task automatic test_back_to_back();
    smp[0] = 16'sd100; smp[1] = 16'sd200; smp[2] = 16'sd300;
    wt[0] = 0; wt[1] = 0; wt[2] = 0;
    run_period(3'b011, 6'b00_00_00, "b2b_first");
    generate_next_sample = 1'b1;
    step();
    vectors++;
    if (overrun !== 1'b1 || eng_req !== 1'b0 || mix_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_overrun: ovr=%b req=%b valid=%b required 1 0 0", overrun, eng_req, mix_valid);
    end
    smp[0] = -16'sd1; smp[1] = 16'sd77;
    run_period(3'b110, 6'b11_00_00, "b2b_second");
    step();
  endtask

  task automatic test_random();
    logic [NV-1:0]   act;
    logic [2*NV-1:0] side;
    for (int n = 0; n < 20; n++) begin
      act  = NV'($urandom);
      side = (2*NV)'($urandom);
      for (int i = 0; i < NV; i++) begin
        smp[i] = SW'($urandom);
        wt[i] = $urandom_range(0, 2);
      end
      run_period(act, side, "random");
      step();
      repeat ($urandom_range(0, 2)) step();
    end
  endtask

  task automatic test_reset_mid();
    voice_active = 3'b011;
    voice_side = '0;
    generate_next_sample = 1'b1;
    step();
    generate_next_sample = 1'b0;
    eng_ack = 1'b1;
    eng_sample = 16'd100;
    step();
    eng_ack = 1'b0;
    vectors++;
    if (eng_req !== 1'b1 || eng_voice !== 2'd1) begin
      miscompares++;
      $display("FAIL pre_reset: req=%b voice=%0d required 1 1", eng_req, eng_voice);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if ({eng_req, eng_voice, mix_valid, overrun, mix_left, mix_right} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: req=%b voice=%0d valid=%b ovr=%b l=%h r=%h required all 0",
               eng_req, eng_voice, mix_valid, overrun, mix_left, mix_right);
    end
    #1 reset = 1'b0;
    expOverrun = 1'b0;
    step();
    smp[0] = 16'sd8; smp[1] = -16'sd4;
    wt[0] = 0; wt[1] = 1;
    run_period(3'b011, 6'b00_01_10, "after_reset");
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_waits();
    test_overrun();
    test_side_change();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
